// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read port plus VGA DAC pins of the scanout block.
// The scanout side is the master; the framebuffer/board side is the slave.
interface vga_fb_scanout_if;
  logic [12:0] fb_addr;
  logic [23:0] fb_data;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic        VGA_CLK;
  logic        vblank;
  logic        frame_tick;

  modport master (
    output fb_addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N,
    output VGA_CLK, vblank, frame_tick,
    input  fb_data
  );

  modport slave (
    input  fb_addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N,
    input  VGA_CLK, vblank, frame_tick,
    output fb_data
  );
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA timing generator and framebuffer scanout: 128x64 image scaled by 2^SCALE_LOG2, centred.
// Latency: 2 pixel ticks from counters to pins; free-running, no backpressure.
module vga_fb_scanout #(
  parameter int          H_VIS      = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_VIS      = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          X_OFF      = 64,
  parameter int          Y_OFF      = 112,
  parameter int          SCALE_LOG2 = 2,
  parameter logic [23:0] BORDER     = 24'h000000
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  vga_fb_scanout_if.master  vga
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_L = HW'(H_VIS);
  localparam logic [HW-1:0] HS_LO   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_HI   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [HW-1:0] X_LO    = HW'(X_OFF);
  localparam logic [HW-1:0] X_HI    = HW'(X_OFF + (128 << SCALE_LOG2));
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_L = VW'(V_VIS);
  localparam logic [VW-1:0] VS_LO   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_HI   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [VW-1:0] Y_LO    = VW'(Y_OFF);
  localparam logic [VW-1:0] Y_HI    = VW'(Y_OFF + (64 << SCALE_LOG2));

  logic          pix_ph;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          tick, h_last, v_last, active, in_win, hs_n, vs_n;
  logic [6:0]    col;
  logic [5:0]    row;
  logic          s0_vld, s0_win, s0_act, s0_hs, s0_vs;

  always_comb begin
    tick   = pix_ph;
    h_last = (h == H_LAST);
    v_last = (v == V_LAST);
    active = (h < H_VIS_L) && (v < V_VIS_L);
    in_win = (h >= X_LO) && (h < X_HI) && (v >= Y_LO) && (v < Y_HI);
    hs_n   = !((h >= HS_LO) && (h < HS_HI));
    vs_n   = !((v >= VS_LO) && (v < VS_HI));
    col    = 7'((h - X_LO) >> SCALE_LOG2);
    row    = 6'((v - Y_LO) >> SCALE_LOG2);
  end

  // vblank follows the line counter directly so software sees it without pipeline lag
  assign vga.vblank = (v >= V_VIS_L);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pix_ph          <= 1'b0;
      h               <= '0;
      v               <= '0;
      vga.VGA_CLK     <= 1'b0;
      vga.frame_tick  <= 1'b0;
      vga.fb_addr     <= '0;
      s0_vld          <= 1'b0;
      s0_win          <= 1'b0;
      s0_act          <= 1'b0;
      s0_hs           <= 1'b1;
      s0_vs           <= 1'b1;
      vga.VGA_R       <= '0;
      vga.VGA_G       <= '0;
      vga.VGA_B       <= '0;
      vga.VGA_HS      <= 1'b1;
      vga.VGA_VS      <= 1'b1;
      vga.VGA_BLANK_N <= 1'b0;
    end else begin
      pix_ph         <= ~pix_ph;
      vga.VGA_CLK    <= ~pix_ph;
      vga.frame_tick <= 1'b0;
      if (tick) begin
        if (h_last) begin
          h <= '0;
          v <= v_last ? '0 : v + VW'(1);
        end else begin
          h <= h + HW'(1);
        end
        vga.frame_tick <= h_last && v_last;

        // Stage 0: issue the read and capture the decode for this pixel
        if (in_win) vga.fb_addr <= {row, col};
        s0_vld <= 1'b1;
        s0_win <= in_win;
        s0_act <= active;
        s0_hs  <= hs_n;
        s0_vs  <= vs_n;

        // Stage 1: read data has had two cycles to return; drive the DAC
        if (s0_vld) begin
          {vga.VGA_R, vga.VGA_G, vga.VGA_B} <= s0_win ? vga.fb_data
                                             : (s0_act ? BORDER : 24'h000000);
          vga.VGA_HS      <= s0_hs;
          vga.VGA_VS      <= s0_vs;
          vga.VGA_BLANK_N <= s0_act;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench: a reduced-geometry scanout checked pixel by pixel over two frames and a reset,
// plus a full 640x480 instance checked over the first lines.
module tb_vga_fb_scanout;
  typedef struct packed {
    int hvis, hfp, hsync, hbp, vvis, vfp, vsync, vbp, xoff, yoff, sh;
    logic [23:0] border;
  } geom_t;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs, vs, blank, vclk, vblank, ftick;
    logic [12:0] addr;
  } pins_t;

  localparam geom_t GS = '{hvis:132, hfp:2, hsync:4, hbp:2, vvis:66, vfp:1, vsync:2, vbp:1,
                           xoff:2, yoff:1, sh:0, border:24'h0000FF};
  localparam geom_t GF = '{hvis:640, hfp:16, hsync:96, hbp:48, vvis:480, vfp:10, vsync:2, vbp:33,
                           xoff:64, yoff:112, sh:2, border:24'h000000};
  localparam int HT_S = 140;
  localparam int FR_S = 140 * 70;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b1;
  always #10 CLOCK_50 = ~CLOCK_50;

  vga_fb_scanout_if fs ();
  vga_fb_scanout_if ff ();

  vga_fb_scanout #(
    .H_VIS(GS.hvis), .H_FP(GS.hfp), .H_SYNC(GS.hsync), .H_BP(GS.hbp),
    .V_VIS(GS.vvis), .V_FP(GS.vfp), .V_SYNC(GS.vsync), .V_BP(GS.vbp),
    .X_OFF(GS.xoff), .Y_OFF(GS.yoff), .SCALE_LOG2(GS.sh), .BORDER(GS.border)
  ) dut_s (.CLOCK_50(CLOCK_50), .reset_n(reset_n), .vga(fs));

  vga_fb_scanout dut_f (.CLOCK_50(CLOCK_50), .reset_n(reset_n), .vga(ff));

  int          n_chk = 0;
  int          n_err = 0;
  int          n = 0;
  bit          seg1 = 1'b0;
  logic [23:0] key = 24'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [23:0] fbv(input int a);
    logic [12:0] a13;
    a13 = 13'(a);
    return {11'h0, a13} ^ key;
  endfunction

  function automatic int wa(input geom_t g, input int h, input int v);
    return (((v - g.yoff) >> g.sh) << 7) + ((h - g.xoff) >> g.sh);
  endfunction

  // Address left on fb_addr after the tick for pixel index t: last in-window pixel so far
  function automatic int last_addr(input geom_t g, input int t);
    int ht, fr, h, v, w, hh;
    ht = g.hvis + g.hfp + g.hsync + g.hbp;
    fr = ht * (g.vvis + g.vfp + g.vsync + g.vbp);
    h  = t % ht;
    v  = (t % fr) / ht;
    w  = 128 << g.sh;
    hh = 64 << g.sh;
    if (v >= g.yoff + hh) return wa(g, g.xoff + w - 1, g.yoff + hh - 1);
    if (v >= g.yoff) begin
      if (h >= g.xoff) return wa(g, (h < g.xoff + w) ? h : g.xoff + w - 1, v);
      if (v > g.yoff) return wa(g, g.xoff + w - 1, v - 1);
    end
    return (t >= fr) ? wa(g, g.xoff + w - 1, g.yoff + hh - 1) : 0;
  endfunction

  // Expected pins n clock edges after reset release (n=0: in or just out of reset)
  function automatic pins_t model(input geom_t g, input int n_in);
    pins_t e;
    int ht, vt, fr, t, c, p, hp, vp;
    bit act, win;
    ht = g.hvis + g.hfp + g.hsync + g.hbp;
    vt = g.vvis + g.vfp + g.vsync + g.vbp;
    fr = ht * vt;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (n_in < 1) return e;
    e.vclk = n_in[0];
    if (n_in < 2) return e;
    t = (n_in - 2) / 2;
    c = t + 1;
    e.vblank = ((c % fr) / ht) >= g.vvis;
    e.ftick  = !n_in[0] && ((c % fr) == 0);
    e.addr   = 13'(last_addr(g, t));
    p = t - 1;
    if (p >= 0) begin
      hp  = p % ht;
      vp  = (p / ht) % vt;
      act = (hp < g.hvis) && (vp < g.vvis);
      win = (hp >= g.xoff) && (hp < g.xoff + (128 << g.sh)) &&
            (vp >= g.yoff) && (vp < g.yoff + (64 << g.sh));
      e.rgb   = win ? fbv(wa(g, hp, vp)) : (act ? g.border : 24'h0);
      e.hs    = !((hp >= g.hvis + g.hfp) && (hp < g.hvis + g.hfp + g.hsync));
      e.vs    = !((vp >= g.vvis + g.vfp) && (vp < g.vvis + g.vfp + g.vsync));
      e.blank = act;
    end
    return e;
  endfunction

  always @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) n <= 0;
    else          n <= n + 1;
  end

  // Framebuffer with one-cycle read latency
  initial begin
    fs.fb_data = 24'h0;
    ff.fb_data = 24'h0;
  end
  always @(posedge CLOCK_50) begin
    fs.fb_data <= fbv(int'(fs.fb_addr));
    ff.fb_data <= fbv(int'(ff.fb_addr));
  end

  int hs_fall[$], hs_rise[$], bl_rise[$], bl_fall[$];
  int vs_fall[$], vs_rise[$], vb_rise[$], vb_fall[$], ft_q[$], ft_post[$], vclk_r[$];
  logic p_hs = 1'b1, p_bl = 1'b0, p_vs = 1'b1, p_vb = 1'b0, p_vclk = 1'b0;

  always @(negedge CLOCK_50) begin
    pins_t gs, gf;
    int    nn;
    nn = reset_n ? n : 0;
    gs = {fs.VGA_R, fs.VGA_G, fs.VGA_B, fs.VGA_HS, fs.VGA_VS, fs.VGA_BLANK_N,
          fs.VGA_CLK, fs.vblank, fs.frame_tick, fs.fb_addr};
    gf = {ff.VGA_R, ff.VGA_G, ff.VGA_B, ff.VGA_HS, ff.VGA_VS, ff.VGA_BLANK_N,
          ff.VGA_CLK, ff.vblank, ff.frame_tick, ff.fb_addr};
    chk("pins_small", 64'(gs), 64'(model(GS, nn)));
    chk("pins_full", 64'(gf), 64'(model(GF, nn)));
    if (reset_n && !seg1) begin
      if (p_hs && !ff.VGA_HS) hs_fall.push_back(n);
      if (!p_hs && ff.VGA_HS) hs_rise.push_back(n);
      if (!p_bl && ff.VGA_BLANK_N) bl_rise.push_back(n);
      if (p_bl && !ff.VGA_BLANK_N) bl_fall.push_back(n);
      if (p_vs && !fs.VGA_VS) vs_fall.push_back(n);
      if (!p_vs && fs.VGA_VS) vs_rise.push_back(n);
      if (!p_vb && fs.vblank) vb_rise.push_back(n);
      if (p_vb && !fs.vblank) vb_fall.push_back(n);
      if (!p_vclk && fs.VGA_CLK) vclk_r.push_back(n);
      if (fs.frame_tick) ft_q.push_back(n);
    end
    if (reset_n && seg1 && fs.frame_tick) ft_post.push_back(n);
    p_hs = ff.VGA_HS; p_bl = ff.VGA_BLANK_N; p_vs = fs.VGA_VS;
    p_vb = fs.vblank; p_vclk = fs.VGA_CLK;
  end

  task automatic wait_n(input int target);
    int guard;
    guard = 0;
    while (n < target && guard < 100000) begin
      @(negedge CLOCK_50);
      guard++;
    end
    chk("wait_n", 64'(n), 64'(target));
  endtask

  function automatic int gap(input int a, input int b, input bit ok);
    return ok ? b - a : -1;
  endfunction

  int          px[8] = '{1, 2, 3, 134, 2, 130, 129, 5};
  int          py[8] = '{1, 1, 1, 1, 2, 11, 64, 67};
  logic [23:0] pe[8];
  logic        pb[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int rv, rh, hold, p;
    key = 24'($urandom);
    pe = '{24'h0000FF, fbv(0), fbv(1), 24'h0, fbv(12'h080), 24'h0000FF, fbv(13'h1FFF), 24'h0};

    #1 reset_n = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    chk("rst_hs", 64'(fs.VGA_HS), 64'(1));
    chk("rst_vs", 64'(ff.VGA_VS), 64'(1));
    chk("rst_blank", 64'(fs.VGA_BLANK_N), 64'(0));
    chk("rst_vclk", 64'(fs.VGA_CLK), 64'(0));
    chk("rst_addr", 64'(fs.fb_addr), 64'(0));
    #2 reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      p = py[i] * HT_S + px[i];
      wait_n(2 * p + 4);
      chk("pix_rgb", 64'({fs.VGA_R, fs.VGA_G, fs.VGA_B}), 64'(pe[i]));
      chk("pix_blank", 64'(fs.VGA_BLANK_N), 64'(pb[i]));
    end

    wait_n(4 * FR_S + 2);
    chk("vclk_period", 64'(gap(vclk_r[0], vclk_r[1], vclk_r.size() > 1)), 64'(2));
    chk("hs_fall_n", 64'(hs_fall.size() > 0 ? hs_fall[0] : -1), 64'(1316));
    chk("hs_period", 64'(gap(hs_fall[0], hs_fall[1], hs_fall.size() > 1)), 64'(1600));
    chk("hs_low", 64'(gap(hs_fall[0], hs_rise[0], hs_rise.size() > 0)), 64'(192));
    chk("blank_high", 64'(gap(bl_rise[0], bl_fall[0], bl_fall.size() > 0)), 64'(1280));
    chk("vs_period", 64'(gap(vs_fall[0], vs_fall[1], vs_fall.size() > 1)), 64'(2 * FR_S));
    chk("vs_low", 64'(gap(vs_fall[0], vs_rise[0], vs_rise.size() > 0)), 64'(2 * 2 * HT_S));
    chk("vblank_high", 64'(gap(vb_rise[0], vb_fall[0], vb_fall.size() > 0)), 64'(2 * 4 * HT_S));
    chk("ft_count", 64'(ft_q.size()), 64'(2));
    chk("ft_first", 64'(ft_q.size() > 0 ? ft_q[0] : -1), 64'(2 * FR_S));

    rv = $urandom_range(1, 20);
    rh = $urandom_range(0, HT_S - 1);
    hold = $urandom_range(2, 4);
    wait_n(2 * (2 * FR_S + rv * HT_S + rh) + 4);
    #2 reset_n = 1'b0;
    seg1 = 1'b1;
    #1;
    chk("mid_rst_rgb", 64'({fs.VGA_R, fs.VGA_G, fs.VGA_B}), 64'(0));
    chk("mid_rst_hs", 64'(fs.VGA_HS), 64'(1));
    chk("mid_rst_vs", 64'(fs.VGA_VS), 64'(1));
    chk("mid_rst_blank", 64'(fs.VGA_BLANK_N), 64'(0));
    chk("mid_rst_addr", 64'(fs.fb_addr), 64'(0));
    repeat (hold) @(negedge CLOCK_50);
    #2 reset_n = 1'b1;

    wait_n(2 * (GS.yoff * HT_S + GS.xoff) + 4);
    chk("post_win_rgb", 64'({fs.VGA_R, fs.VGA_G, fs.VGA_B}), 64'(fbv(0)));
    wait_n(2 * FR_S);
    chk("post_ft", 64'(fs.frame_tick), 64'(1));
    @(negedge CLOCK_50);
    chk("post_ft_count", 64'(ft_post.size()), 64'(1));
    chk("post_ft_n", 64'(ft_post.size() > 0 ? ft_post[0] : -1), 64'(2 * FR_S));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
